// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: active-low glyph table and the
// decoded-slot record used by the scan decoder and future encoder checks.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  // Active-low patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       bad;
  } seg7_slot_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: active-low segment pattern to {nibble, blank, bad}.
// Unknown patterns decode to nibble 0 with bad set.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output seg7_slot_t slot
);

  always_comb begin
    slot = '{nibble: 4'h0, blank: 1'b0, bad: 1'b0};
    case (pattern)
      SEG_0:     slot.nibble = 4'h0;
      SEG_1:     slot.nibble = 4'h1;
      SEG_2:     slot.nibble = 4'h2;
      SEG_3:     slot.nibble = 4'h3;
      SEG_4:     slot.nibble = 4'h4;
      SEG_5:     slot.nibble = 4'h5;
      SEG_6:     slot.nibble = 4'h6;
      SEG_7:     slot.nibble = 4'h7;
      SEG_8:     slot.nibble = 4'h8;
      SEG_9:     slot.nibble = 4'h9;
      SEG_A:     slot.nibble = 4'hA;
      SEG_B:     slot.nibble = 4'hB;
      SEG_C:     slot.nibble = 4'hC;
      SEG_D:     slot.nibble = 4'hD;
      SEG_E:     slot.nibble = 4'hE;
      SEG_F:     slot.nibble = 4'hF;
      SEG_BLANK: slot.blank  = 1'b1;
      default:   slot.bad    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for the multiplexed 7-segment bus: waits for each scan slot to
// settle, decodes it, and publishes a complete frame with a one-cycle valid pulse.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   anodes,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    stalled
);

  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);

  // Stage S and its previous value
  logic [6:0]            seg_s_q, seg_p_q;
  logic [NUM_DIGITS-1:0] an_s_q, an_p_q;

  logic [SetW-1:0] settle_q, settle_d;
  logic [ToW-1:0]  timeout_q, timeout_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic            err_acc_q, err_acc_d;

  logic [NUM_DIGITS-1:0][3:0] stage_nib_q;
  logic [NUM_DIGITS-1:0]      stage_blank_q;

  logic [4*NUM_DIGITS-1:0] frame_digits_q;
  logic [NUM_DIGITS-1:0]   frame_blank_q;
  logic                    frame_valid_q;
  logic                    frame_err_q;

  logic            bus_changed;
  logic            settle_fire;
  logic [CntW-1:0] low_cnt;
  logic [IdxW-1:0] slot_idx;
  logic            capture;
  logic            multi_anode;
  logic            frame_done;
  seg7_slot_t      dec;

  seg7_glyph_decode u_glyph_decode (
    .pattern (seg_s_q),
    .slot    (dec)
  );

  assign bus_changed = {an_s_q, seg_s_q} != {an_p_q, seg_p_q};

  always_comb begin
    settle_d = settle_q;
    if (bus_changed) begin
      settle_d = '0;
    end else if (settle_q < SetW'(SETTLE_CYCLES)) begin
      settle_d = settle_q + SetW'(1);
    end
  end

  // Fires only on the step into SETTLE_CYCLES, so a long hold yields a single capture.
  assign settle_fire = !bus_changed && (settle_q == SetW'(SETTLE_CYCLES - 1));

  always_comb begin
    low_cnt  = '0;
    slot_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s_q[i]) begin
        low_cnt  = low_cnt + CntW'(1);
        slot_idx = IdxW'(i);
      end
    end
  end

  assign capture     = settle_fire && (low_cnt == CntW'(1));
  assign multi_anode = settle_fire && (low_cnt > CntW'(1));
  assign frame_done  = &seen_q;

  // A capture landing in the completion cycle starts the next frame.
  always_comb begin
    seen_d    = frame_done ? '0 : seen_q;
    err_acc_d = frame_done ? 1'b0 : err_acc_q;
    if (capture) begin
      seen_d[slot_idx] = 1'b1;
      if (dec.bad) begin
        err_acc_d = 1'b1;
      end
    end
    if (multi_anode) begin
      err_acc_d = 1'b1;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (capture) begin
      timeout_d = '0;
    end else if (timeout_q < ToW'(TIMEOUT_CYCLES)) begin
      timeout_d = timeout_q + ToW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s_q   <= '0;
      seg_p_q   <= '0;
      an_s_q    <= '0;
      an_p_q    <= '0;
      settle_q  <= '0;
      timeout_q <= '0;
      seen_q    <= '0;
      err_acc_q <= 1'b0;
    end else begin
      seg_s_q   <= segments;
      seg_p_q   <= seg_s_q;
      an_s_q    <= anodes;
      an_p_q    <= an_s_q;
      settle_q  <= settle_d;
      timeout_q <= timeout_d;
      seen_q    <= seen_d;
      err_acc_q <= err_acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_nib_q   <= '0;
      stage_blank_q <= '0;
    end else if (capture) begin
      stage_nib_q[slot_idx]   <= dec.nibble;
      stage_blank_q[slot_idx] <= dec.blank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_digits_q <= '0;
      frame_blank_q  <= '0;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= frame_done;
      if (frame_done) begin
        frame_digits_q <= stage_nib_q;
        frame_blank_q  <= stage_blank_q;
        frame_err_q    <= err_acc_q;
      end
    end
  end

  assign frame_digits = frame_digits_q;
  assign frame_blank  = frame_blank_q;
  assign frame_valid  = frame_valid_q;
  assign frame_err    = frame_err_q;
  assign stalled      = (timeout_q >= ToW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives scan slots on the bus and checks the
// published frames, settle timing, multi-anode errors, stall timeout and reset.
module tb_seg7_scan_decoder;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  segments = 7'h7F;
  logic [7:0]  anodes = 8'hFF;
  logic [31:0] frame_digits;
  logic [7:0]  frame_blank;
  logic        frame_valid;
  logic        frame_err;
  logic        stalled;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fv_count = 0;
  int fv_cyc = 0;

  seg7_scan_decoder #(
    .NUM_DIGITS     (8),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .segments     (segments),
    .anodes       (anodes),
    .frame_digits (frame_digits),
    .frame_blank  (frame_blank),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err),
    .stalled      (stalled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count <= fv_count + 1;
      fv_cyc   <= cyc;
    end
  end

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46; 13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // Called #1 after a posedge; leaves the bus held for hold clocks.
  task automatic drive_slot(input int idx, input logic [6:0] seg, input int hold);
    anodes   = ~(8'h01 << idx);
    segments = seg;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({frame_digits, frame_blank, frame_valid, frame_err, stalled} !== 43'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h/%h/%b/%b/%b required all zero",
               frame_digits, frame_blank, frame_valid, frame_err, stalled);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int base;
    base = fv_count;
    for (int i = 0; i < 8; i++) drive_slot(i, glyph(i), 10);
    checks++;
    if (fv_count - base !== 1) begin
      failures++;
      $display("FAIL basic_pulses: got %0d required 1", fv_count - base);
    end
    checks++;
    if (frame_digits !== 32'h76543210 || frame_blank !== 8'h00 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_frame: got %h/%h/%b required 76543210/00/0",
               frame_digits, frame_blank, frame_err);
    end
  endtask

  task automatic test_blank();
    logic [6:0] pat [8];
    pat[0] = 7'h0E; pat[1] = 7'h24; pat[2] = 7'h08; pat[3] = 7'h79;
    for (int i = 4; i < 8; i++) pat[i] = 7'h7F;
    for (int i = 0; i < 8; i++) drive_slot(i, pat[i], 10);
    checks++;
    if (frame_digits !== 32'h00001A2F || frame_blank !== 8'hF0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL blank_frame: got %h/%h/%b required 00001a2f/f0/0",
               frame_digits, frame_blank, frame_err);
    end
  endtask

  task automatic test_bad_glyph();
    for (int i = 0; i < 8; i++) drive_slot(i, (i == 2) ? 7'h7E : glyph(i), 10);
    checks++;
    if (frame_digits !== 32'h76543010 || frame_blank !== 8'h00 || frame_err !== 1'b1) begin
      failures++;
      $display("FAIL bad_glyph_frame: got %h/%h/%b required 76543010/00/1",
               frame_digits, frame_blank, frame_err);
    end
    for (int i = 0; i < 8; i++) drive_slot(i, glyph(i), 10);
    checks++;
    if (frame_digits !== 32'h76543210 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL clean_after_err: got %h/%b required 76543210/0", frame_digits, frame_err);
    end
  endtask

  task automatic test_glitch();
    int base;
    int t;
    base = fv_count;
    t    = 0;
    for (int i = 0; i < 8; i++) begin
      drive_slot(i, 7'h7E, 3);
      t = cyc;
      drive_slot(i, glyph(8 + i), 10);
    end
    checks++;
    if (fv_count - base !== 1) begin
      failures++;
      $display("FAIL glitch_pulses: got %0d required 1", fv_count - base);
    end
    checks++;
    if (frame_digits !== 32'hFEDCBA98 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL glitch_frame: got %h/%b required fedcba98/0", frame_digits, frame_err);
    end
    // Stage-S edge, capture SETTLE+1 edges later, frame_valid one edge after that.
    checks++;
    if (fv_cyc - t !== 7) begin
      failures++;
      $display("FAIL glitch_latency: got %0d required 7", fv_cyc - t);
    end
  endtask

  task automatic test_multi_anode();
    int base;
    base = fv_count;
    for (int i = 2; i < 8; i++) drive_slot(i, glyph(i), 10);
    anodes   = 8'b1111_1100;
    segments = glyph(5);
    repeat (10) @(posedge clk);
    #1;
    drive_slot(0, glyph(0), 10);
    checks++;
    if (fv_count !== base) begin
      failures++;
      $display("FAIL multi_no_seen: got %0d pulses required 0", fv_count - base);
    end
    drive_slot(1, glyph(1), 10);
    checks++;
    if (fv_count - base !== 1 || frame_digits !== 32'h76543210 || frame_err !== 1'b1) begin
      failures++;
      $display("FAIL multi_frame: got %0d/%h/%b required 1/76543210/1",
               fv_count - base, frame_digits, frame_err);
    end
  endtask

  task automatic test_stall();
    int base;
    int t;
    int rise;
    base = fv_count;
    rise = -1;
    drive_slot(0, glyph(15), 10);
    drive_slot(1, glyph(14), 10);
    t = cyc;
    drive_slot(2, glyph(13), 10);
    anodes   = 8'hFF;
    segments = 7'h7F;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stalled) begin
        rise = cyc;
        break;
      end
    end
    // Capture lands 6 edges after the drive, then TIMEOUT edges to saturate.
    checks++;
    if (rise - t !== 70) begin
      failures++;
      $display("FAIL stall_rise: got %0d required 70 (rise=%0d)", rise - t, rise);
    end
    @(posedge clk);
    #1;
    anodes   = ~8'h08;
    segments = glyph(12);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stalled !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold: got %b required 1", stalled);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (stalled !== 1'b0) begin
      failures++;
      $display("FAIL stall_fall: got %b required 0", stalled);
    end
    repeat (4) @(posedge clk);
    #1;
    for (int i = 4; i < 7; i++) drive_slot(i, glyph(15 - i), 10);
    checks++;
    if (fv_count !== base) begin
      failures++;
      $display("FAIL stall_early_valid: got %0d pulses required 0", fv_count - base);
    end
    drive_slot(7, glyph(8), 10);
    checks++;
    if (fv_count - base !== 1 || frame_digits !== 32'h89ABCDEF || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL stall_frame: got %0d/%h/%b required 1/89abcdef/0",
               fv_count - base, frame_digits, frame_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    for (int i = 0; i < 4; i++) drive_slot(i, glyph(i), 10);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({frame_digits, frame_blank, frame_valid, frame_err, stalled} !== 43'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h/%h/%b/%b/%b required all zero",
               frame_digits, frame_blank, frame_valid, frame_err, stalled);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    base = fv_count;
    for (int i = 4; i < 8; i++) drive_slot(i, glyph(i), 10);
    checks++;
    if (fv_count !== base) begin
      failures++;
      $display("FAIL midreset_partial_kept: got %0d pulses required 0", fv_count - base);
    end
    for (int i = 0; i < 4; i++) drive_slot(i, glyph(i), 10);
    checks++;
    if (fv_count - base !== 1 || frame_digits !== 32'h76543210 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_frame: got %0d/%h/%b required 1/76543210/0",
               fv_count - base, frame_digits, frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank();
    test_bad_glyph();
    test_glitch();
    test_multi_anode();
    test_stall();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
